// File: rtl/ssd_scan_arbiter_if.sv
// Display-sharing bus between the two requesters and the scan arbiter.
// The requester side drives Req/Digits/Mask; the arbiter drives grants and the display.
interface ssd_scan_arbiter_if;
   logic        ReqA;
   logic [39:0] DigitsA;
   logic [7:0]  MaskA;
   logic        ReqB;
   logic [39:0] DigitsB;
   logic [7:0]  MaskB;
   logic        GntA;
   logic        GntB;
   logic [7:0]  An;
   logic [4:0]  Digit;
   logic        FrameDone;

   modport master (
      output ReqA, DigitsA, MaskA, ReqB, DigitsB, MaskB,
      input  GntA, GntB, An, Digit, FrameDone
   );

   modport slave (
      input  ReqA, DigitsA, MaskA, ReqB, DigitsB, MaskB,
      output GntA, GntB, An, Digit, FrameDone
   );
endinterface

// File: rtl/ssd_scan_arbiter.sv
// 8-digit seven-segment scan with per-slot blanking, shared between two requesters.
// Ownership changes only at frame boundaries (round-robin with a minimum hold).
module ssd_scan_arbiter #(
   parameter int SCAN_DIV_BITS = 18,
   parameter int BLANK_CYCLES  = 64,
   parameter int HOLD_FRAMES   = 4
) (
   input logic               ClkPort,
   input logic               Reset,
   ssd_scan_arbiter_if.slave bus
);
   typedef enum logic {ST_BLANK = 1'b0, ST_DRIVE = 1'b1} scan_state_t;

   localparam int HW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
   localparam logic [HW-1:0]            HOLD_MAX   = HW'(HOLD_FRAMES);
   localparam logic [SCAN_DIV_BITS-1:0] BLANK_LAST = SCAN_DIV_BITS'(BLANK_CYCLES - 1);

   scan_state_t              r_state, w_state_nxt;
   logic [SCAN_DIV_BITS-1:0] r_slot_cnt;
   logic [2:0]               r_idx;
   logic                     r_gnt_a, r_gnt_b, r_ptr_b;
   logic [HW-1:0]            r_hold, w_hold_inc, w_hold_nxt;
   logic [4:0]               r_digit, w_code;
   logic [39:0]              w_digits;
   logic [7:0]               w_mask, w_an;
   logic                     w_slot_end, w_blank_end, w_frame_done;
   logic                     w_gnt_a_nxt, w_gnt_b_nxt, w_ptr_b_nxt, w_change;

   assign w_slot_end   = &r_slot_cnt;
   assign w_blank_end  = (r_slot_cnt == BLANK_LAST);
   assign w_frame_done = (r_state == ST_DRIVE) && w_slot_end && (r_idx == 3'd7);

   assign w_digits = r_gnt_a ? bus.DigitsA : (r_gnt_b ? bus.DigitsB : '0);
   assign w_mask   = r_gnt_a ? bus.MaskA   : (r_gnt_b ? bus.MaskB   : '0);
   assign w_code   = w_digits[int'(r_idx)*5 +: 5];

   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         r_state    <= ST_BLANK;
         r_slot_cnt <= '0;
         r_idx      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_slot_cnt <= r_slot_cnt + 1'b1;
         if (r_state == ST_DRIVE && w_slot_end)
            r_idx <= r_idx + 3'd1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_an        = 8'hFF;
      case (r_state)
         ST_BLANK: if (w_blank_end) w_state_nxt = ST_DRIVE;
         ST_DRIVE: begin
            if (w_slot_end) w_state_nxt = ST_BLANK;
            if ((r_gnt_a || r_gnt_b) && w_mask[r_idx]) w_an[r_idx] = 1'b0;
         end
         default:  w_state_nxt = ST_BLANK;
      endcase
   end

   // The frame just finishing counts toward the hold, so a grant lasts HOLD_FRAMES full frames.
   assign w_hold_inc = (r_hold >= HOLD_MAX) ? r_hold : r_hold + 1'b1;

   always_comb begin
      w_gnt_a_nxt = r_gnt_a;
      w_gnt_b_nxt = r_gnt_b;
      if (w_frame_done) begin
         if (!r_gnt_a && !r_gnt_b) begin
            if (bus.ReqA && bus.ReqB) begin
               w_gnt_a_nxt = !r_ptr_b;
               w_gnt_b_nxt = r_ptr_b;
            end else begin
               w_gnt_a_nxt = bus.ReqA;
               w_gnt_b_nxt = bus.ReqB;
            end
         end else if (r_gnt_a) begin
            if (!bus.ReqA || (bus.ReqB && w_hold_inc >= HOLD_MAX)) begin
               w_gnt_a_nxt = 1'b0;
               w_gnt_b_nxt = bus.ReqB;
            end
         end else begin
            if (!bus.ReqB || (bus.ReqA && w_hold_inc >= HOLD_MAX)) begin
               w_gnt_b_nxt = 1'b0;
               w_gnt_a_nxt = bus.ReqA;
            end
         end
      end
   end

   // Pointer favours whoever is not holding the display; on release it favours the other side.
   always_comb begin
      w_change    = (w_gnt_a_nxt != r_gnt_a) || (w_gnt_b_nxt != r_gnt_b);
      w_hold_nxt  = r_hold;
      w_ptr_b_nxt = r_ptr_b;
      if (w_change) begin
         w_hold_nxt  = '0;
         w_ptr_b_nxt = w_gnt_a_nxt || (!w_gnt_b_nxt && r_gnt_a);
      end else if (w_frame_done && (r_gnt_a || r_gnt_b)) begin
         w_hold_nxt = w_hold_inc;
      end
   end

   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         r_gnt_a <= 1'b0;
         r_gnt_b <= 1'b0;
         r_ptr_b <= 1'b0;
         r_hold  <= '0;
         r_digit <= '0;
      end else begin
         r_gnt_a <= w_gnt_a_nxt;
         r_gnt_b <= w_gnt_b_nxt;
         r_ptr_b <= w_ptr_b_nxt;
         r_hold  <= w_hold_nxt;
         if (r_state == ST_BLANK && r_slot_cnt == '0)
            r_digit <= w_code;
      end
   end

   assign bus.GntA      = r_gnt_a;
   assign bus.GntB      = r_gnt_b;
   assign bus.An        = w_an;
   assign bus.Digit     = r_digit;
   assign bus.FrameDone = w_frame_done;
endmodule

// File: tb/tb_ssd_scan_arbiter.sv
// Scoreboard bench: stimulus queues expected display state keyed by cycle since reset release,
// plus expected FrameDone cycles; a monitor pops and compares as the DUT presents them.
module tb_ssd_scan_arbiter;
   logic ClkPort;
   logic Reset;
   ssd_scan_arbiter_if bus ();

   ssd_scan_arbiter #(.SCAN_DIV_BITS(4), .BLANK_CYCLES(2), .HOLD_FRAMES(2)) dut (
      .ClkPort (ClkPort),
      .Reset   (Reset),
      .bus     (bus)
   );

   typedef struct {
      int         cyc;
      bit         ca;
      logic [7:0] an;
      bit         cd;
      logic [4:0] dig;
      logic       ga;
      logic       gb;
   } exp_t;

   exp_t q[$];
   int   fdq[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = -1;

   initial begin
      ClkPort = 1'b0;
      forever #5 ClkPort = ~ClkPort;
   end

   task automatic chk(string name, int c, logic [31:0] got, logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
      end
   endtask

   // Monitor: runs on the falling edge, away from the active edge.
   initial begin
      exp_t e;
      int   f;
      forever begin
         @(negedge ClkPort);
         if (Reset) cyc = -1;
         else begin
            cyc++;
            chk("gnt_overlap", cyc, {31'd0, bus.GntA & bus.GntB}, 32'd0);
            if (bus.FrameDone) begin
               if (fdq.size() == 0) chk("fd_unexpected", cyc, 32'd1, 32'd0);
               else begin
                  f = fdq.pop_front();
                  chk("fd_cycle", cyc, cyc, f);
               end
            end
            while (q.size() > 0 && q[0].cyc <= cyc) begin
               e = q.pop_front();
               if (e.cyc < cyc) chk("exp_missed", cyc, e.cyc, cyc);
               else begin
                  if (e.ca) chk("an", cyc, {24'd0, bus.An}, {24'd0, e.an});
                  if (e.cd) chk("digit", cyc, {27'd0, bus.Digit}, {27'd0, e.dig});
                  chk("gnt", cyc, {30'd0, bus.GntA, bus.GntB}, {30'd0, e.ga, e.gb});
               end
            end
         end
      end
   end

   function automatic logic [7:0] lit(int d);
      logic [7:0] m;
      m = 8'hFF;
      m[d] = 1'b0;
      return m;
   endfunction

   function automatic logic [39:0] pack(int base);
      logic [39:0] v;
      for (int d = 0; d < 8; d++) v[5*d +: 5] = 5'(base + d);
      return v;
   endfunction

   task automatic ex(int c, bit ca, logic [7:0] an, bit cd, logic [4:0] dig, logic ga, logic gb);
      exp_t e;
      e.cyc = c; e.ca = ca; e.an = an; e.cd = cd; e.dig = dig; e.ga = ga; e.gb = gb;
      q.push_back(e);
   endtask

   task automatic push_fd(int ncyc);
      for (int k = 127; k < ncyc; k += 128) fdq.push_back(k);
   endtask

   task automatic run(int n);
      repeat (n) @(negedge ClkPort);
      #1;
   endtask

   task automatic finish_check(string name);
      n_cmp++;
      if (q.size() != 0 || fdq.size() != 0) begin
         n_err++;
         $display("FAIL %s_unconsumed got=%0d/%0d want=0/0", name, q.size(), fdq.size());
         q.delete();
         fdq.delete();
      end
   endtask

   task automatic rst_on();
      Reset = 1'b1;
      bus.ReqA = 1'b0; bus.ReqB = 1'b0;
      bus.DigitsA = pack(0); bus.DigitsB = pack(16);
      bus.MaskA = 8'hFF; bus.MaskB = 8'hFF;
      repeat (2) @(posedge ClkPort);
   endtask

   task automatic rst_off();
      @(posedge ClkPort);
      #1 Reset = 1'b0;
   endtask

   initial begin
      Reset = 1'b1;
      // 1: idle display, no requests
      rst_on();
      chk("rst_an", 0, {24'd0, bus.An}, 32'hFF);
      chk("rst_fd", 0, {31'd0, bus.FrameDone}, 32'd0);
      rst_off();
      for (int c = 0; c < 300; c++) ex(c, 1, 8'hFF, 0, 5'd0, 1'b0, 1'b0);
      push_fd(300);
      run(300);
      finish_check("t1");

      // 2: A alone, all digits lit
      rst_on();
      bus.ReqA = 1'b1;
      rst_off();
      ex(127, 1, 8'hFF, 0, 5'd0, 1'b0, 1'b0);
      for (int d = 0; d < 8; d++) begin
         ex(128 + 16*d,      1, 8'hFF,  0, 5'd0,    1'b1, 1'b0);
         ex(128 + 16*d + 1,  1, 8'hFF,  0, 5'd0,    1'b1, 1'b0);
         ex(128 + 16*d + 2,  1, lit(d), 1, 5'(d),   1'b1, 1'b0);
         ex(128 + 16*d + 15, 1, lit(d), 1, 5'(d),   1'b1, 1'b0);
      end
      push_fd(260);
      run(260);
      finish_check("t2");

      // 3: both requesting, 2-frame hold alternation
      rst_on();
      bus.ReqA = 1'b1; bus.ReqB = 1'b1;
      rst_off();
      ex(127, 1, 8'hFF,  0, 5'd0,  1'b0, 1'b0);
      ex(128, 1, 8'hFF,  0, 5'd0,  1'b1, 1'b0);
      ex(130, 1, lit(0), 1, 5'h00, 1'b1, 1'b0);
      ex(383, 1, lit(7), 1, 5'h07, 1'b1, 1'b0);
      ex(384, 1, 8'hFF,  0, 5'd0,  1'b0, 1'b1);
      ex(386, 1, lit(0), 1, 5'h10, 1'b0, 1'b1);
      ex(639, 1, lit(7), 1, 5'h17, 1'b0, 1'b1);
      ex(640, 1, 8'hFF,  0, 5'd0,  1'b1, 1'b0);
      ex(642, 1, lit(0), 1, 5'h00, 1'b1, 1'b0);
      ex(770, 1, lit(0), 1, 5'h00, 1'b1, 1'b0);
      push_fd(778);
      run(778);
      finish_check("t3");

      // 4: partial mask, only digits 0 and 2 lit
      rst_on();
      bus.ReqA = 1'b1; bus.MaskA = 8'b0000_0101;
      rst_off();
      for (int d = 0; d < 8; d++)
         ex(128 + 16*d + 8, 1, (d == 0 || d == 2) ? lit(d) : 8'hFF, 1, 5'(d), 1'b1, 1'b0);
      push_fd(270);
      run(270);
      finish_check("t4");

      // 5: digit 3 changes mid-DRIVE, shown only from the next frame
      rst_on();
      bus.ReqA = 1'b1;
      rst_off();
      ex(183, 1, lit(3), 1, 5'h03, 1'b1, 1'b0);
      ex(190, 1, lit(3), 1, 5'h03, 1'b1, 1'b0);
      ex(191, 1, lit(3), 1, 5'h03, 1'b1, 1'b0);
      ex(306, 1, lit(3), 1, 5'h1F, 1'b1, 1'b0);
      ex(319, 1, lit(3), 1, 5'h1F, 1'b1, 1'b0);
      push_fd(330);
      run(184);
      bus.DigitsA[19:15] = 5'h1F;
      run(330 - 184);
      finish_check("t5");

      // 6: owner drops request mid-frame, then asynchronous reset mid-slot
      rst_on();
      bus.ReqA = 1'b1; bus.DigitsA = pack(16);
      rst_off();
      ex(300, 1, lit(2), 1, 5'h12, 1'b1, 1'b0);
      ex(383, 1, lit(7), 1, 5'h17, 1'b1, 1'b0);
      ex(384, 1, 8'hFF,  0, 5'd0,  1'b0, 1'b0);
      ex(390, 1, 8'hFF,  1, 5'h00, 1'b0, 1'b0);
      ex(511, 1, 8'hFF,  0, 5'd0,  1'b0, 1'b0);
      ex(512, 1, 8'hFF,  0, 5'd0,  1'b1, 1'b0);
      ex(536, 1, lit(1), 1, 5'h11, 1'b1, 1'b0);
      push_fd(537);
      run(301);
      bus.ReqA = 1'b0;
      run(100);
      bus.ReqA = 1'b1;
      run(136);
      Reset = 1'b1;
      #1;
      chk("async_an",  536, {24'd0, bus.An}, 32'hFF);
      chk("async_dig", 536, {27'd0, bus.Digit}, 32'd0);
      chk("async_gnt", 536, {30'd0, bus.GntA, bus.GntB}, 32'd0);
      chk("async_fd",  536, {31'd0, bus.FrameDone}, 32'd0);
      finish_check("t6a");
      repeat (2) @(posedge ClkPort);
      rst_off();
      ex(0,   1, 8'hFF,  0, 5'd0,  1'b0, 1'b0);
      ex(2,   1, 8'hFF,  0, 5'd0,  1'b0, 1'b0);
      ex(127, 1, 8'hFF,  0, 5'd0,  1'b0, 1'b0);
      ex(128, 1, 8'hFF,  0, 5'd0,  1'b1, 1'b0);
      ex(130, 1, lit(0), 1, 5'h10, 1'b1, 1'b0);
      ex(146, 1, lit(1), 1, 5'h11, 1'b1, 1'b0);
      push_fd(150);
      run(150);
      finish_check("t6b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
